// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage RV32 core: post-reset flush,
// load-use / branch hazard resolution, data-memory wait hold with timeout, and operand forwarding.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       Running,
  output logic       MemErr
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_MEMWAIT = 2'd2} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_init_cnt, w_init_nxt;
  logic [7:0] r_wait_cnt, w_wait_nxt;
  logic       r_mem_err, w_err_nxt;
  logic       w_memwait, w_load_use, w_branch;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)
      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_memwait  = MemReqM & ~MemReadyM;
  assign w_load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_branch   = PCSrcE;

  // State follows the pipeline registers, which capture on the falling edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 4'(FLUSH_CYCLES);
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_mem_err  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_mem_err;
    case (r_state)
      ST_INIT: begin
        w_init_nxt = r_init_cnt - 4'd1;
        // A zero count can only come from an illegal parameter; leave rather than wrap
        if (r_init_cnt <= 4'd1)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_memwait) begin
          w_state_nxt = ST_MEMWAIT;
          w_wait_nxt  = 8'd1;
        end
      end
      ST_MEMWAIT: begin
        if (w_memwait) begin
          w_wait_nxt = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 8'd0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
    if (w_state_nxt == ST_MEMWAIT && w_wait_nxt == 8'(TIMEOUT))
      w_err_nxt = 1'b1;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (r_state == ST_INIT) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      if (w_memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (w_branch) begin
        // A taken branch squashes the instruction the load-use stall would have held
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign Running = (r_state != ST_INIT);
  assign MemErr  = r_mem_err;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage RV32 core. It generates the stall, flush and forwarding controls for the F/D/E/M/W pipeline registers. It runs a post-reset flush sequence and resolves load-use and branch hazards. It also holds the pipeline on a multi-cycle data-memory handshake, with a timeout watchdog. It sits beside the inter-stage registers and drives their stall/flush inputs.

## Interface
Parameters:
- FLUSH_CYCLES, 2: falling edges after reset release during which every stage is flushed (legal range 1..15).
- TIMEOUT, 15: memory-wait cycles after which MemErr is set (legal range 1..255).

Ports:
- clk  in  1  core clock; all state updates on the falling edge, matching the pipeline registers.
- reset  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in E.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- RdM, RdW  in  5  destinations in M and W.
- RegWriteM, RegWriteW  in  1  register-write enables in M and W.
- MemReqM  in  1  load or store active in M.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into the corresponding register.
- ForwardAE, ForwardBE  out  2  E operand source: 00 register file, 01 W result, 10 M ALU result.
- Running  out  1  controller has left INIT.
- MemErr  out  1  sticky memory-timeout flag.

## Operation
- States: INIT, RUN, MEMWAIT. Internal registers: a 4-bit init counter and an 8-bit saturating wait counter.
- INIT:
  - Entered asynchronously while reset=0; init counter loads FLUSH_CYCLES, wait counter 0, MemErr 0.
  - Outputs: StallF=1, all Flush*=1, other stalls 0, Running=0.
  - Each falling edge with reset=1 decrements the counter. On the edge where it equals 1, go to RUN.
- Memory stall: memwait = MemReqM & ~MemReadyM, evaluated in RUN and MEMWAIT.
  - memwait=1 gives StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0.
  - Load-use and branch actions are suppressed while memwait=1; they are re-evaluated once it clears.
- RUN to MEMWAIT: on a falling edge with memwait=1. The wait counter loads 1.
- MEMWAIT:
  - Each falling edge with memwait=1 increments the wait counter, saturating at 255.
  - When the counter reaches TIMEOUT, MemErr is set. The controller keeps waiting.
  - A falling edge with MemReadyM=1 or MemReqM=0 returns to RUN and clears the wait counter.
- Load-use (RUN or MEMWAIT with memwait=0): condition is ResultSrcE==2'b01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - Response: StallF=1, StallD=1, FlushE=1, for one cycle.
- Branch (memwait=0): PCSrcE=1 gives FlushD=1, FlushE=1.
  - If load-use also holds, the branch wins: StallF=StallD=0.
- Forwarding (combinational, every state except INIT, where it is forced to 00):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Otherwise 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Otherwise 00. The M stage has priority over W.
  - ForwardBE uses Rs2E with the same rules.
- MemErr clears only on reset.

## Timing
- Stall, flush and forward outputs are combinational from the current state and inputs; no added latency.
- State and counters change only on the falling edge of clk or asynchronously on reset.
- Reset values: StallF=1, FlushD=FlushE=FlushM=FlushW=1, StallD=StallE=StallM=0, ForwardAE=ForwardBE=00, Running=0, MemErr=0.
- Reset released with FLUSH_CYCLES=2: Running rises after the second falling edge.
- A load-use stall costs exactly 1 cycle.
- A memory access completing after N wait cycles holds the pipeline N cycles. The stall drops combinationally in the same cycle MemReadyM rises.
- Reset asserted in MEMWAIT: immediate return to INIT; MemErr and all counters clear.
- MemReqM dropping without MemReadyM: memwait clears immediately; MEMWAIT exits on the next falling edge.

## Test plan
- Reset, release, FLUSH_CYCLES=2 -> all Flush*=1 and StallF=1 through 2 falling edges; then Running=1 and all flushes 0.
- ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 -> no stall.
- RdM=RdW=7 with RegWriteM=RegWriteW=1, Rs1E=7 -> ForwardAE=10. Clear RegWriteM -> 01. Rs1E=0 -> 00.
- MemReqM=1 with MemReadyM low for 3 cycles, then high -> StallF/D/E/M=1 and FlushW=1 for 3 cycles; 0 in the cycle ready rises; state RUN next edge.
- TIMEOUT=4, MemReadyM held low for 6 cycles -> MemErr=1 after the 4th wait edge; stays 1 after ready; clears only on reset.
- PCSrcE=1 coincident with the load-use condition -> FlushD=FlushE=1, StallF=StallD=0. Assert reset mid-MEMWAIT -> reset output values immediately.
